// File: rtl/pipeline_control_if.sv
// Hazard-controller bundle: latch status from the pipeline in, latch/PC/memory controls out.
// The slave side is the controller; the master side is the pipeline or a testbench.
interface pipeline_control_if #(
   parameter int unsigned CNT_W = 16
);
   logic             ihit;
   logic             dhit;
   logic             exmem_dREN;
   logic             exmem_dWEN;
   logic             exmem_halt;
   logic [1:0]       exmem_PCsrc;
   logic             exmem_ZeroFlag;
   logic             idex_dREN;
   logic [4:0]       idex_wsel;
   logic [4:0]       ifid_rs;
   logic [4:0]       ifid_rt;

   logic             dREN;
   logic             dWEN;
   logic             pc_en;
   logic             pc_redirect;
   logic             ifid_en;
   logic             ifid_flush;
   logic             idex_en;
   logic             idex_flush;
   logic             exmem_en;
   logic             exmem_flush;
   logic             memwb_en;
   logic             memwb_flush;
   logic             halt;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] redirect_cnt;

   modport master (
      output ihit, dhit, exmem_dREN, exmem_dWEN, exmem_halt, exmem_PCsrc,
             exmem_ZeroFlag, idex_dREN, idex_wsel, ifid_rs, ifid_rt,
      input  dREN, dWEN, pc_en, pc_redirect, ifid_en, ifid_flush, idex_en,
             idex_flush, exmem_en, exmem_flush, memwb_en, memwb_flush, halt,
             stall_cnt, redirect_cnt
   );

   modport slave (
      input  ihit, dhit, exmem_dREN, exmem_dWEN, exmem_halt, exmem_PCsrc,
             exmem_ZeroFlag, idex_dREN, idex_wsel, ifid_rs, ifid_rt,
      output dREN, dWEN, pc_en, pc_redirect, ifid_en, ifid_flush, idex_en,
             idex_flush, exmem_en, exmem_flush, memwb_en, memwb_flush, halt,
             stall_cnt, redirect_cnt
   );
endinterface

// File: rtl/pipeline_control.sv
// Five-stage pipeline hazard/sequencing controller: data stalls, redirects,
// load-use interlock, fetch-miss bubbles, sticky halt and saturating perf counters.
module pipeline_control #(
   parameter int unsigned CNT_W = 16
) (
   input logic               CLK,
   input logic               RST,
   pipeline_control_if.slave bus
);

   typedef enum logic [1:0] {RUN, DWAIT, HALTED} state_t;

   state_t           state, state_next;
   logic [CNT_W-1:0] stall_cnt_q, redirect_cnt_q;

   logic halted, memreq, data_stall, taken, load_use;
   logic pc_en, pc_redirect;
   logic ifid_en, ifid_flush, idex_en, idex_flush;
   logic exmem_en, exmem_flush, memwb_en, memwb_flush;

   assign halted     = (state == HALTED);
   assign memreq     = bus.exmem_dREN | bus.exmem_dWEN;
   assign data_stall = memreq & ~bus.dhit & ~halted;
   assign taken      = (bus.exmem_PCsrc == 2'b01 && bus.exmem_ZeroFlag) ||
                       (bus.exmem_PCsrc == 2'b10) || (bus.exmem_PCsrc == 2'b11);
   assign load_use   = bus.idex_dREN && (bus.idex_wsel != 5'd0) &&
                       ((bus.idex_wsel == bus.ifid_rs) || (bus.idex_wsel == bus.ifid_rt));

   always_comb begin
      state_next  = state;
      pc_en       = 1'b1;
      pc_redirect = 1'b0;
      ifid_en     = 1'b1;
      ifid_flush  = 1'b0;
      idex_en     = 1'b1;
      idex_flush  = 1'b0;
      exmem_en    = 1'b1;
      exmem_flush = 1'b0;
      memwb_en    = 1'b1;
      memwb_flush = 1'b0;

      if (halted || data_stall) begin
         pc_en    = 1'b0;
         ifid_en  = 1'b0;
         idex_en  = 1'b0;
         exmem_en = 1'b0;
         memwb_en = 1'b0;
         if (data_stall) state_next = DWAIT;
      end else begin
         state_next = RUN;
         // Halt outranks a coincident redirect: retire through MEM/WB only, then freeze.
         if (bus.exmem_halt) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_en    = 1'b0;
            exmem_en   = 1'b0;
            state_next = HALTED;
         end else if (taken) begin
            pc_redirect = 1'b1;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
         end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
         end else if (!bus.ihit) begin
            pc_en      = 1'b0;
            ifid_flush = 1'b1;
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state          <= RUN;
         stall_cnt_q    <= '0;
         redirect_cnt_q <= '0;
      end else begin
         state <= state_next;
         if (!halted && !pc_en && stall_cnt_q != '1)
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         if (pc_redirect && redirect_cnt_q != '1)
            redirect_cnt_q <= redirect_cnt_q + CNT_W'(1);
      end
   end

   assign bus.dREN         = bus.exmem_dREN & ~halted;
   assign bus.dWEN         = bus.exmem_dWEN & ~halted;
   assign bus.pc_en        = pc_en;
   assign bus.pc_redirect  = pc_redirect;
   assign bus.ifid_en      = ifid_en;
   assign bus.ifid_flush   = ifid_flush;
   assign bus.idex_en      = idex_en;
   assign bus.idex_flush   = idex_flush;
   assign bus.exmem_en     = exmem_en;
   assign bus.exmem_flush  = exmem_flush;
   assign bus.memwb_en     = memwb_en;
   assign bus.memwb_flush  = memwb_flush;
   assign bus.halt         = halted;
   assign bus.stall_cnt    = stall_cnt_q;
   assign bus.redirect_cnt = redirect_cnt_q;

endmodule

// File: doc/pipeline_control.md
# pipeline_control

Hazard and sequencing controller for the five-stage pipeline. It owns the `en`/`flush` controls of the IF/ID, ID/EX, EX/MEM and MEM/WB latches and the PC enable. It also issues data-memory requests for the instruction held in EX/MEM, redirects the PC on branches and jumps resolved in MEM, and latches halt. It sits beside the latches and consumes their registered outputs plus the cache hit strobes.

## Interface
Parameters:
- CNT_W, 16, width of the saturating performance counters.

Ports:
- CLK  in  1  pipeline clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-high reset.
- ihit  in  1  instruction fetch complete this cycle.
- dhit  in  1  data access complete this cycle.
- exmem_dREN, exmem_dWEN  in  1 each  EX/MEM `dREN_o` / `dWEN_o`.
- exmem_halt  in  1  EX/MEM `halt_o`.
- exmem_PCsrc  in  2  EX/MEM `PCsrc_o`: 00 sequential, 01 branch, 10 jump, 11 jump-register.
- exmem_ZeroFlag  in  1  EX/MEM `ZeroFlag_o`.
- idex_dREN  in  1  ID/EX holds a load.
- idex_wsel  in  5  ID/EX destination register.
- ifid_rs, ifid_rt  in  5 each  IF/ID source registers.
- dREN, dWEN  out  1 each  gated data-memory request.
- pc_en  out  1  PC register load enable.
- pc_redirect  out  1  PC selects the EX/MEM target instead of PC+4.
- ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en, memwb_flush  out  1 each  latch controls. Flush loads a bubble at the edge and has priority over `en`.
- halt  out  1  sticky core halt.
- stall_cnt  out  CNT_W  cycles with any stall asserted, saturating.
- redirect_cnt  out  CNT_W  taken redirects, saturating.

## Operation
- FSM states: RUN, DWAIT, HALTED. Reset state is RUN.
- `memreq = exmem_dREN | exmem_dWEN`. `dREN`/`dWEN` follow the EX/MEM inputs in RUN and DWAIT and are 0 in HALTED.
- Data stall: `memreq & ~dhit` in RUN or DWAIT.
  - All `en`=0, all `flush`=0, `pc_en`=0.
  - RUN→DWAIT. DWAIT holds until `dhit`.
- On `dhit` (RUN or DWAIT), the pipeline advances normally and the FSM returns to RUN.
- Taken redirect: `taken = (PCsrc==01 & ZeroFlag) | PCsrc==10 | PCsrc==11`. When `taken` and there is no data stall:
  - `pc_redirect`=1, `pc_en`=1.
  - `ifid_flush`=`idex_flush`=`exmem_flush`=1.
  - `memwb_en`=1.
  - `redirect_cnt` increments.
- Load-use: `idex_dREN & idex_wsel!=0 & (idex_wsel==ifid_rs | idex_wsel==ifid_rt)`. When this holds, with no data stall and no `taken`:
  - `pc_en`=0, `ifid_en`=0, `idex_flush`=1.
  - `exmem_en`=`memwb_en`=1.
- Fetch miss: `~ihit`, with no higher-priority condition:
  - `pc_en`=0, `ifid_flush`=1.
  - Downstream latches advance.
- Normal operation: all `en`=1, all `flush`=0, `pc_en`=1.
- Priority order: HALTED > data stall > taken redirect > load-use > fetch miss > normal.
- Halt: when `exmem_halt` and there is no data stall, `memwb_en`=1 for that cycle and the FSM goes to HALTED.
  - In HALTED: all `en`=0, `flush`=0, `pc_en`=0, `halt`=1.
  - HALTED is left only by reset.
  - A halt coinciding with `taken` takes the halt path; no redirect is issued.
- `stall_cnt` increments in any cycle where `pc_en`=0 outside HALTED.
- Both counters saturate at all-ones and do not wrap.

## Timing
- All control outputs are combinational from the FSM state and the current inputs. No added latency: a stall or flush decided in cycle N takes effect at the edge ending cycle N.
- The FSM, `halt` and the counters are registered.
- Reset values:
  - FSM=RUN, `halt`=0, `stall_cnt`=0, `redirect_cnt`=0.
  - During reset, outputs evaluate as RUN with the current inputs.
- Asserting RST in DWAIT or HALTED returns to RUN immediately (asynchronous). No stale stall persists after reset.
- A request with `dhit` in its first cycle never enters DWAIT and costs zero stall cycles.

## Test plan
- Load in EX/MEM with `dhit` arriving 3 cycles late → 3 cycles with all `en`=0 and `dREN`=1; FSM visits DWAIT; advance on the 4th cycle; `stall_cnt`=3.
- Branch in EX/MEM, PCsrc=01, ZeroFlag=1 → `pc_redirect`=1 and three flushes for 1 cycle, `redirect_cnt`=1. With ZeroFlag=0 → normal advance.
- ID/EX load with wsel=5 and IF/ID rs=5 → one cycle with `pc_en`=`ifid_en`=0 and `idex_flush`=1. With wsel=0 → no stall.
- `~ihit` for 2 cycles with no other hazard → `ifid_flush`=1 and `pc_en`=0 for 2 cycles; ID/EX, EX/MEM and MEM/WB advance.
- `exmem_halt` together with `taken` → no redirect; `halt`=1 next cycle and stays high; all enables stay 0.
- RST asserted mid-DWAIT → FSM returns to RUN and counters clear asynchronously. Force 2^CNT_W+5 stall cycles → `stall_cnt` holds at all-ones.
